// File: rtl/text_console.sv
// text_console: character-cell text buffer with cursor, scroll and clears.
// Ports: clk/reset(active-low async); key_in/p_valid/p_ready keyboard
// handshake; x/y/v_addr renderer probe in; ascii_out/row char and glyph
// line out; cur_x/cur_y/cursor_hit cursor position and renderer match.
module text_console #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int CW     = 7,
  parameter int RW     = 5,
  parameter int FONT_H = 16,
  localparam int LH    = $clog2(FONT_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [CW-1:0] x,
  input  logic [RW-1:0] y,
  input  logic [9:0]    v_addr,
  output logic [7:0]    ascii_out,
  output logic [LH-1:0] row,
  output logic [CW-1:0] cur_x,
  output logic [RW-1:0] cur_y,
  output logic          cursor_hit
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_CLR_ROW = 2'd2;
  localparam logic [1:0] S_CLR_ALL = 2'd3;

  localparam logic [CW-1:0] X_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] Y_LAST = RW'(ROWS - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [AW-1:0] A_COLS = AW'(COLS);
  localparam logic [AW-1:0] A_XL   = AW'(COLS - 1);
  localparam logic [RW:0]   R_NUM  = ROWS[RW:0];
  localparam logic [RW:0]   R_LAST = R_NUM - (RW+1)'(1);

  logic [7:0]    mem [N];
  logic [1:0]    state, state_n;
  logic [AW-1:0] clr_cnt, cnt_n;
  logic [CW-1:0] cx_n;
  logic [RW-1:0] cy_n, top, top_n;
  logic          we;
  logic [AW-1:0] wa;
  logic [7:0]    wd;
  logic          acc, nl, is_print;
  logic [RW-1:0] rd_prow, cur_prow, prev_prow, bot_prow;
  logic [9:0]    y_pix, v_off;

  // Logical row to physical row: (r + t) mod ROWS, one conditional subtract.
  function automatic logic [RW-1:0] prow(
    input logic [RW-1:0] r,
    input logic [RW-1:0] t
  );
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s > R_LAST) s = s - R_NUM;
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr(
    input logic [RW-1:0] pr,
    input logic [CW-1:0] c
  );
    return AW'(pr) * A_COLS + AW'(c);
  endfunction

  assign p_ready    = (state == S_IDLE);
  assign acc        = p_valid && p_ready;
  assign is_print   = (key_in >= 8'h20) && (key_in <= 8'h7E);
  assign cursor_hit = (x == cur_x) && (y == cur_y);

  assign rd_prow   = prow(y, top);
  assign cur_prow  = prow(cur_y, top);
  assign prev_prow = (cur_prow == '0) ? Y_LAST : cur_prow - RW'(1);
  // After a scroll the old top physical row becomes the new bottom.
  assign bot_prow  = (top == '0) ? Y_LAST : top - RW'(1);

  assign y_pix = 10'(y) << LH;
  assign v_off = v_addr - y_pix;
  assign row   = v_off[LH-1:0];

  always_comb begin
    ascii_out = mem[addr(rd_prow, x)];
    if (x > X_LAST || y > Y_LAST) ascii_out = 8'h00;
    // Hide the stale bottom row while it is being wiped.
    if (state == S_CLR_ROW && y == Y_LAST) ascii_out = 8'h00;
  end

  always_comb begin
    state_n = state;
    cnt_n   = clr_cnt;
    cx_n    = cur_x;
    cy_n    = cur_y;
    top_n   = top;
    we      = 1'b0;
    wa      = clr_cnt;
    wd      = 8'h00;
    nl      = 1'b0;
    unique case (state)
      S_INIT, S_CLR_ALL: begin
        we = 1'b1;
        if (clr_cnt == A_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = clr_cnt + AW'(1);
        end
      end
      S_CLR_ROW: begin
        we = 1'b1;
        wa = addr(bot_prow, '0) + clr_cnt;
        if (clr_cnt == A_XL) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = clr_cnt + AW'(1);
        end
      end
      S_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_print: begin
              we = 1'b1;
              wa = addr(cur_prow, cur_x);
              wd = key_in;
              if (cur_x == X_LAST) begin
                cx_n = '0;
                nl   = 1'b1;
              end else begin
                cx_n = cur_x + CW'(1);
              end
            end
            key_in == 8'h0A: begin
              cx_n = '0;
              nl   = 1'b1;
            end
            key_in == 8'h0D: cx_n = '0;
            key_in == 8'h08: begin
              if (cur_x != '0) begin
                cx_n = cur_x - CW'(1);
                we   = 1'b1;
                wa   = addr(cur_prow, cur_x - CW'(1));
              end else if (cur_y != '0) begin
                cx_n = X_LAST;
                cy_n = cur_y - RW'(1);
                we   = 1'b1;
                wa   = addr(prev_prow, X_LAST);
              end
            end
            key_in == 8'h0C: begin
              cx_n    = '0;
              cy_n    = '0;
              top_n   = '0;
              state_n = S_CLR_ALL;
              cnt_n   = '0;
            end
            default: ;
          endcase
          if (nl) begin
            if (cur_y != Y_LAST) begin
              cy_n = cur_y + RW'(1);
            end else begin
              top_n   = (top == Y_LAST) ? '0 : top + RW'(1);
              state_n = S_CLR_ROW;
              cnt_n   = '0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      top     <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= cnt_n;
      cur_x   <= cx_n;
      cur_y   <= cy_n;
      top     <= top_n;
    end
  end

endmodule

// File: doc/text_console.md
# text_console

Parametrised character-cell text buffer that sits between the PS/2 keyboard decoder and the VGA text renderer. It accepts one ASCII code per handshake and maintains a cursor. It interprets control codes (newline, carriage return, backspace, form feed), scrolls the screen when the last row overflows, and serves a combinational character read port to the renderer. Cell clearing (reset, scroll, form feed) is sequential, one cell per cycle, with input back-pressure while it runs.

## Interface
- COLS, 70, characters per row.
- ROWS, 30, rows on screen.
- CW, 7, column-index width; must satisfy 2^CW >= COLS.
- RW, 5, row-index width; must satisfy 2^RW >= ROWS.
- FONT_H, 16, glyph height in pixel lines (power of two).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  8  ASCII code offered by the keyboard path.
- p_valid  in  1  key_in valid; a key is accepted on a cycle with p_valid && p_ready.
- p_ready  out  1  block can accept a key.
- x  in  CW  renderer column (logical).
- y  in  RW  renderer row (logical, 0 = top of screen).
- v_addr  in  10  renderer pixel line.
- ascii_out  out  8  character at (x, y); combinational.
- row  out  log2(FONT_H)  glyph line = (v_addr - y*FONT_H) truncated.
- cur_x  out  CW  cursor column.
- cur_y  out  RW  cursor row (logical).
- cursor_hit  out  1  (x == cur_x) && (y == cur_y).

## Operation
- Storage: ROWS*COLS bytes. Physical address = prow*COLS + col, where prow = (logical row + top) mod ROWS. top is the scroll offset, range 0..ROWS-1.
- States: INIT, IDLE, CLR_ROW, CLR_ALL. A single counter clr_cnt drives all three clear states.
- INIT: entered while reset is low. Clears every cell to 0x00, one per cycle, ROWS*COLS cycles, then goes to IDLE. No async reset is applied to the array.
- IDLE, key accepted:
  - 0x20..0x7E: write key_in at (cur_x, cur_y). If cur_x == COLS-1, set cur_x = 0 and do a newline step; else cur_x++.
  - 0x0A: cur_x = 0, then newline step.
  - 0x0D: cur_x = 0, cur_y unchanged.
  - 0x08 (backspace):
    - cur_x > 0: cur_x--, and the new cell is written 0x00.
    - cur_x == 0 && cur_y > 0: move to (COLS-1, cur_y-1) and write that cell 0x00.
    - At (0,0): no-op.
  - 0x0C: go to CLR_ALL. Cursor becomes (0,0) and top becomes 0.
  - Any other code: accepted and ignored.
- Newline step:
  - cur_y < ROWS-1: cur_y++.
  - Otherwise cur_y stays ROWS-1, top = (top+1) mod ROWS, and the block goes to CLR_ROW. CLR_ROW clears the new bottom physical row, COLS cycles.
- CLR_ROW and CLR_ALL return to IDLE after their last clear write.
- p_ready = 1 only in IDLE.
- Read port:
  - ascii_out = 0x00 if x >= COLS or y >= ROWS.
  - ascii_out = 0x00 for logical row ROWS-1 while in CLR_ROW, so stale text is masked.
  - Otherwise ascii_out = mem[phys(x, y)].

## Timing
- While reset is low: cur_x = 0, cur_y = 0, top = 0, state = INIT, clr_cnt = 0, p_ready = 0. The cell contents are undefined.
- After reset is released: p_ready rises after exactly ROWS*COLS clock edges (2100 at default parameters).
- Printable or backspace write: visible on ascii_out, and on the cursor outputs, the cycle after acceptance. p_ready stays 1.
- Scroll: top and the cursor update on the accept edge. p_ready is 0 for exactly COLS cycles (70), then returns to 1.
- Form feed: p_ready is 0 for ROWS*COLS cycles.
- Wrap at the last column of the last row: a single accept writes the cell and also starts the scroll.
- Asserting reset mid-clear aborts immediately and restarts INIT.
- top wraps from ROWS-1 to 0. All mod-ROWS arithmetic uses compare-and-subtract, not division.
- row is a pure combinational subtraction, truncated to log2(FONT_H) bits.

## Test plan
- Reset release: count cycles until p_ready rises; expect 2100. Every (x < 70, y < 30) then reads 0x00, and cursor_hit is 1 at (0,0).
- Type "AB", then 0x0A, then "C": (0,0)=0x41, (1,0)=0x42, (0,1)=0x43; cursor ends at (1,1).
- Type 70 × 'x' on row 0: cursor goes to (0,1), no scroll, and p_ready stays 1 throughout.
- Backspace:
  - Cursor at (0,1) after the previous test: 0x08 moves the cursor to (69,0), and (69,0) reads 0x00.
  - 0x08 at (0,0) changes nothing.
- Scroll:
  - Write "R<n>" on each row n = 0..29, then 0x0A on row 29. p_ready is 0 for exactly 70 cycles.
  - Afterwards logical row 0 shows "R1", row 29 is all 0x00, and the cursor is (0,29).
  - Repeat 30 times; top wraps back to 0.
- Form feed during text: all cells read 0x00, the cursor is (0,0), and p_ready is low for 2100 cycles. Pulse reset mid-clear; verify the full INIT restarts.
